alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares one combinational 32-bit ALU between two requesters, e.g. the main execute stage and an address/branch helper unit. Each requester uses its own valid/ready request channel and its own valid/ready response channel. The arbiter registers the granted operation, drives the ALU for one cycle, captures the result and flags, and holds the response until the owning requester accepts it. Grant order is round-robin, or fixed priority when configured.

Parameters:
FAIR, 1, 1 = round-robin between requesters; 0 = requester 0 always wins a tie
IDLE_CTRL, 4'b0000, ALU control code driven while no operation is in flight

Ports:
i_clk  input  1  clock, rising-edge
i_rst_n  input  1  reset, asynchronous, active-low
i_req_valid  input  2  bit k = requester k presents an operation
o_req_ready  output  2  bit k = arbiter accepts requester k this cycle
i_req_ctrl0, i_req_ctrl1  input  4  ALU control code from requester 0 / 1
i_req_a0, i_req_a1  input  32  first operand from requester 0 / 1
i_req_b0, i_req_b1  input  32  second operand from requester 0 / 1
o_alu_ctrl  output  4  control code to the ALU
o_alu_1, o_alu_2  output  32  operands to the ALU
i_alu_out  input  32  ALU result
i_alu_zero, i_alu_neg, i_alu_negU  input  1  ALU flags
o_rsp_valid  output  2  one-hot; response pending for requester k
i_rsp_ready  input  2  requester k accepts its response
o_rsp_data  output  32  captured result, shared by both requesters
o_rsp_zero, o_rsp_neg, o_rsp_negU  output  1  captured flags
o_rsp_err  output  1  the operation used an illegal control code
o_busy  output  1  state is not IDLE

Behaviour:
- One clock domain. Reset is asynchronous and active-low. Clock and reset ports are i_clk and i_rst_n.
- Reset values:
  - state = IDLE, last-grant pointer = 1 (requester 0 wins the first tie), owner = 0.
  - o_req_ready = 0, o_rsp_valid = 0, o_rsp_data = 0, all rsp flags = 0, o_rsp_err = 0, o_busy = 0.
  - o_alu_ctrl = IDLE_CTRL, o_alu_1 = o_alu_2 = 0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - o_req_ready is combinational. If only one requester is valid, ready goes to that requester. If both are valid, ready goes to the requester not equal to the last-grant pointer when FAIR = 1, or to requester 0 when FAIR = 0. At most one ready bit is set.
  - On valid&ready: latch ctrl/a/b and the owner, update the last-grant pointer to the owner, go to EXEC.
- EXEC (exactly 1 cycle):
  - o_alu_ctrl/o_alu_1/o_alu_2 come from the latched registers. The ALU outputs must never depend on unlatched requester inputs.
  - At the clock edge, capture i_alu_out and the three flags, then go to RESP.
  - Legal codes: 0000 add, 0001 sub, 0010 or, 0011 and, 0100 xor, 0101 sra, 0110 srl, 0111 sll, 1101 slt, 1110 sltu.
  - Any other code sets o_rsp_err = 1 and forces o_rsp_data = 0 and all flags = 0, ignoring the ALU's undefined output.
- RESP:
  - o_rsp_valid[owner] = 1 and the data/flags/err outputs stay stable.
  - When i_rsp_ready[owner] = 1: go to IDLE at the edge, o_rsp_valid drops next cycle. i_rsp_ready of the non-owner is ignored.
- Outside EXEC the ALU inputs are held at IDLE_CTRL/0/0.
- The response registers keep the last value after handoff. Only o_rsp_valid qualifies them.
- Latency is 2 cycles from the accept edge to o_rsp_valid high. Back-to-back throughput is one operation per 3 cycles when the response is accepted immediately.
- o_req_ready is 0 in EXEC and RESP. No request is accepted while an operation is in flight.
- A requester must hold its valid and operands stable until accepted. The arbiter does not check this.
- A new request arriving in the same cycle a response is accepted waits one cycle and is accepted in the following IDLE cycle.
- Reset asserted mid-operation returns the block to reset values immediately. Any in-flight response is discarded and no o_rsp_valid pulse is produced.
- An operand is 32 bits with no width conversion. The shift amount is passed to the ALU unmodified.

Test Plan:
- Single op: req0 valid, ctrl 0000, a = 5, b = 7 -> ready0 pulses at cycle 0, o_alu_ctrl = 0000 with operands 5/7 at cycle 1, o_rsp_valid = 01 with data 12, zero 0, neg 0 at cycle 2.
- Flags: req1 ctrl 0001, a = 3, b = 3 -> data 0, zero 1, negU 0. Then a = 2, b = 3 -> data 0xFFFFFFFF, neg 1, negU 1, o_rsp_valid = 10.
- Tie with FAIR = 1, both requesters valid continuously -> grants alternate 0,1,0,1. With FAIR = 0 -> all grants go to 0 while req0 stays valid.
- Backpressure: hold i_rsp_ready = 0 for 5 cycles -> o_rsp_valid and data stay stable, o_req_ready = 00 throughout. Asserting i_rsp_ready of the wrong requester has no effect.
- Illegal code: ctrl 1000 -> o_rsp_err = 1, data 0, flags 0. The next legal op clears err.
- Reset mid-EXEC: drop i_rst_n during EXEC -> all outputs at reset values immediately, no o_rsp_valid after release, and the next tie is granted to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two valid/ready requesters,
// round-robin or fixed priority, with a registered operation and a held response.
module alu_arbiter #(
  parameter bit         FAIR      = 1'b1,
  parameter logic [3:0] IDLE_CTRL = 4'b0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [3:0]  i_req_ctrl0,
  input  logic [3:0]  i_req_ctrl1,
  input  logic [31:0] i_req_a0,
  input  logic [31:0] i_req_a1,
  input  logic [31:0] i_req_b0,
  input  logic [31:0] i_req_b1,
  output logic [3:0]  o_alu_ctrl,
  output logic [31:0] o_alu_1,
  output logic [31:0] o_alu_2,
  input  logic [31:0] i_alu_out,
  input  logic        i_alu_zero,
  input  logic        i_alu_neg,
  input  logic        i_alu_negU,
  output logic [1:0]  o_rsp_valid,
  input  logic [1:0]  i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_zero,
  output logic        o_rsp_neg,
  output logic        o_rsp_negU,
  output logic        o_rsp_err,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last, owner, pick, legal, accept;
  logic [3:0] ctrl_q;
  logic [31:0] a_q, b_q;
  always_comb begin
    pick = &i_req_valid ? (FAIR ? ~last : 1'b0) : i_req_valid[1];
    accept = state == IDLE && |i_req_valid;
    o_req_ready = accept ? (pick ? 2'b10 : 2'b01) : 2'b00;
    legal = ctrl_q <= 4'd7 || ctrl_q == 4'd13 || ctrl_q == 4'd14;
    o_alu_ctrl = state == EXEC ? ctrl_q : IDLE_CTRL;
    o_alu_1 = state == EXEC ? a_q : 32'd0;
    o_alu_2 = state == EXEC ? b_q : 32'd0;
    o_rsp_valid = state == RESP ? (owner ? 2'b10 : 2'b01) : 2'b00;
    o_busy = state != IDLE;
    state_nx = state == IDLE ? (accept ? EXEC : IDLE) :
               state == EXEC ? RESP :
               (i_rsp_ready[owner] ? IDLE : RESP);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      owner <= 1'b0;
      ctrl_q <= 4'd0;
      a_q <= 32'd0;
      b_q <= 32'd0;
      o_rsp_data <= 32'd0;
      o_rsp_zero <= 1'b0;
      o_rsp_neg <= 1'b0;
      o_rsp_negU <= 1'b0;
      o_rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner <= pick;
        last <= pick;
        ctrl_q <= pick ? i_req_ctrl1 : i_req_ctrl0;
        a_q <= pick ? i_req_a1 : i_req_a0;
        b_q <= pick ? i_req_b1 : i_req_b0;
      end
      // illegal codes discard whatever the ALU produced
      if (state == EXEC) begin
        o_rsp_data <= legal ? i_alu_out : 32'd0;
        o_rsp_zero <= legal & i_alu_zero;
        o_rsp_neg <= legal & i_alu_neg;
        o_rsp_negU <= legal & i_alu_negU;
        o_rsp_err <= ~legal;
      end
    end
  end
endmodule
